// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok bus between the fetch port and the data port,
// routing in-order responses back through an ID FIFO. Define SRAM_ARB_RR_EN for round-robin ties.
module sram_bus_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int PTR_W       = $clog2(OUTSTANDING)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_sram_req,
  input  logic             inst_sram_wr,
  input  logic [1:0]       inst_sram_size,
  input  logic [3:0]       inst_sram_wstrb,
  input  logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_wdata,
  output logic             inst_sram_addr_ok,
  output logic             inst_sram_data_ok,
  output logic [31:0]      inst_sram_rdata,
  input  logic             data_sram_req,
  input  logic             data_sram_wr,
  input  logic [1:0]       data_sram_size,
  input  logic [3:0]       data_sram_wstrb,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic             data_sram_addr_ok,
  output logic             data_sram_data_ok,
  output logic [31:0]      data_sram_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic             dbg_lock,
  output logic [PTR_W:0]   dbg_count
);

  localparam int CNT_W = PTR_W + 1;

  // Handshake: a source's req stays high until its addr_ok; mem_req holds the same
  // winner until mem_addr_ok; every accepted request gets exactly one data_ok, in order.
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} arb_state_t;

  arb_state_t              state;
  logic                    grant_src;
  logic [OUTSTANDING-1:0]  fifo_id;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic                    winner;
  logic                    win_unlocked;
  logic                    win_req;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    head_id;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;
  // On a tie the source that did not win the last accept goes next.
  assign win_unlocked = (inst_sram_req && data_sram_req) ? ~last_grant : data_sram_req;
`else
  // Data wins ties: its access is older in program order than the fetch.
  assign win_unlocked = data_sram_req;
`endif

  assign winner  = (state == LOCKED) ? grant_src : win_unlocked;
  assign win_req = winner ? data_sram_req : inst_sram_req;
  assign full    = (count == CNT_W'(OUTSTANDING));
  assign mem_req = resetn & ~full & win_req;

  assign mem_wr    = winner ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = winner ? data_sram_size  : inst_sram_size;
  assign mem_wstrb = winner ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_addr  = winner ? data_sram_addr  : inst_sram_addr;
  assign mem_wdata = winner ? data_sram_wdata : inst_sram_wdata;

  assign push = mem_req & mem_addr_ok;
  assign inst_sram_addr_ok = push & ~winner;
  assign data_sram_addr_ok = push & winner;

  // A response with nothing outstanding is a bus protocol error and is ignored.
  assign head_id = fifo_id[rd_ptr];
  assign pop     = resetn & mem_data_ok & (count != '0);
  assign inst_sram_data_ok = pop & ~head_id;
  assign data_sram_data_ok = pop & head_id;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  assign dbg_lock  = (state == LOCKED);
  assign dbg_count = count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= UNLOCKED;
      grant_src <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
`ifdef SRAM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        UNLOCKED: if (mem_req && !mem_addr_ok) begin
          state     <= LOCKED;
          grant_src <= winner;
        end
        LOCKED:   if (mem_addr_ok) state <= UNLOCKED;
        default:  state <= UNLOCKED;
      endcase
      if (push) begin
        fifo_id[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + PTR_W'(1);
`ifdef SRAM_ARB_RR_EN
        last_grant      <= winner;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: accepted requests queue {source, response data},
// responses pop and check routing. Honors SRAM_ARB_RR_EN for the tie-break model.
module tb_sram_bus_arbiter;

  localparam int OUTS = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] inst_sram_addr, data_sram_addr, data_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        dbg_lock;
  logic [1:0]  dbg_count;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];
  int   m_count;
  logic m_lock, m_gsrc, m_last;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTSTANDING(OUTS)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(1'b0), .inst_sram_size(2'd2),
    .inst_sram_wstrb(4'h0), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(32'h0),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .dbg_lock(dbg_lock), .dbg_count(dbg_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_count = 0; m_lock = 1'b0; m_gsrc = 1'b0; m_last = 1'b1;
    inst_sram_addr  = 32'h1c000000;
    data_sram_addr  = 32'h1c008000;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd2;
    data_sram_wstrb = 4'hf;
    data_sram_wdata = 32'h0;
  endtask

  // One bus cycle: drive, check against the model mid-cycle, clock, update the model.
  task automatic cyc(input logic ireq, input logic dreq, input logic aok, input logic dok,
                     input logic [31:0] rd);
    logic full_e, win, wreq, mreq_e, push_e, pop_e;
    logic [32:0] e;
    inst_sram_req = ireq; data_sram_req = dreq;
    mem_addr_ok = aok; mem_data_ok = dok;
    pop_e = dok && (m_count != 0);
    e = pop_e ? exp_q[0] : 33'h0;
    mem_rdata = pop_e ? e[31:0] : $urandom();
    #1;
    check_eq("count", 64'(dbg_count), 64'(m_count));
    check_eq("lock", 64'(dbg_lock), 64'(m_lock));
    full_e = (m_count == OUTS);
    if (m_lock) win = m_gsrc;
`ifdef SRAM_ARB_RR_EN
    else if (ireq && dreq) win = ~m_last;
`endif
    else win = dreq;
    wreq = win ? dreq : ireq;
    mreq_e = !full_e && wreq;
    check_eq("mem_req", 64'(mem_req), 64'(mreq_e));
    if (mreq_e) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(win ? data_sram_addr : inst_sram_addr));
      check_eq("mem_wr", 64'(mem_wr), 64'(win ? data_sram_wr : 1'b0));
      check_eq("mem_size", 64'(mem_size), 64'(win ? data_sram_size : 2'd2));
      check_eq("mem_wstrb", 64'(mem_wstrb), 64'(win ? data_sram_wstrb : 4'h0));
      check_eq("mem_wdata", 64'(mem_wdata), 64'(win ? data_sram_wdata : 32'h0));
    end
    push_e = mreq_e && aok;
    check_eq("inst_addr_ok", 64'(inst_sram_addr_ok), 64'(push_e && !win));
    check_eq("data_addr_ok", 64'(data_sram_addr_ok), 64'(push_e && win));
    check_eq("inst_data_ok", 64'(inst_sram_data_ok), 64'(pop_e && !e[32]));
    check_eq("data_data_ok", 64'(data_sram_data_ok), 64'(pop_e && e[32]));
    if (pop_e) begin
      check_eq("inst_rdata", 64'(inst_sram_rdata), 64'(e[31:0]));
      check_eq("data_rdata", 64'(data_sram_rdata), 64'(e[31:0]));
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    if (push_e) begin
      exp_q.push_back({win, rd});
      m_last = win;
      if (win) begin
        data_sram_addr  = data_sram_addr + 32'd4;
        data_sram_wr    = 1'($urandom_range(0, 1));
        data_sram_size  = 2'($urandom_range(0, 2));
        data_sram_wstrb = 4'($urandom_range(0, 15));
        data_sram_wdata = $urandom();
      end else begin
        inst_sram_addr = inst_sram_addr + 32'd4;
      end
    end
    m_count = m_count + int'(push_e) - int'(pop_e);
    if (!m_lock && mreq_e && !aok) begin
      m_lock = 1'b1; m_gsrc = win;
    end else if (m_lock && aok) begin
      m_lock = 1'b0;
    end
  endtask

  // Reset with requests and responses active: every handshake output must be held low.
  task automatic do_reset();
    resetn = 1'b0;
    inst_sram_req = 1'b1; data_sram_req = 1'b1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'h0);
    check_eq("rst_addr_ok", 64'({inst_sram_addr_ok, data_sram_addr_ok}), 64'h0);
    check_eq("rst_data_ok", 64'({inst_sram_data_ok, data_sram_data_ok}), 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_count != 0; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    logic ir, dr;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // single fetch, response two cycles after accept
    cyc(1, 0, 1, 0, 32'h02800c0c);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h0);
    // spurious response with nothing outstanding
    cyc(0, 0, 0, 1, 32'h0);

    // two tie cycles back to back
    cyc(1, 1, 1, 0, 32'h11110000);
    cyc(1, 1, 1, 0, 32'h22220000);
    drain();

    // lock: inst waits three cycles, data rises meanwhile
    cyc(1, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0);
    cyc(1, 1, 1, 0, 32'h33330000);
    cyc(0, 1, 1, 0, 32'h44440000);
    drain();

    // full: third request blocked, a pop does not free a slot the same cycle
    cyc(1, 0, 1, 0, 32'haaaa0000);
    cyc(0, 1, 1, 0, 32'hbbbb0000);
    cyc(1, 0, 1, 0, 32'h0);
    cyc(1, 0, 1, 1, 32'h0);
    cyc(1, 0, 1, 1, 32'hcccc0000);
    drain();

    // push+pop at count 1 over back-to-back transactions
    cyc(1, 0, 1, 0, 32'h50000000);
    for (int i = 0; i < 10; i++) cyc(i[0], ~i[0], 1, 1, 32'h50000001 + 32'(i));
    drain();

    // reset while locked with a request outstanding
    cyc(1, 0, 1, 0, 32'h66660000);
    cyc(0, 1, 0, 0, 32'h0);
    do_reset();
    cyc(1, 0, 1, 0, 32'h77770000);
    cyc(0, 0, 0, 1, 32'h0);

    // random traffic; a locked source keeps its request raised
    for (int i = 0; i < 300; i++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (m_lock && !m_gsrc) ir = 1'b1;
      if (m_lock && m_gsrc)  dr = 1'b1;
      cyc(ir, dr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
    end
    drain();
    check_eq("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
